rf_write_arbiter: RTL and testbench

//  Owns the single write port of the 16x8 register file.
//  - After reset, clears registers 1..2**D-1 to zero.
//  - Then shares the write port between two writeback requesters, ALU and MEM (load),

---
 rtl/rf_ctrl_pkg.sv | 10 +
 rtl/rr_arb2.sv | 21 ++
 rtl/rf_write_arbiter.sv | 134 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types for the register-file write-port controller.
package rf_ctrl_pkg;

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} rf_state_t;
  typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} rf_req_t;

  localparam int unsigned RF_W = 8;
  localparam int unsigned RF_D = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; req/grant bit 0 is ALU, bit 1 is MEM.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  rf_req_t    last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie, the requester that did not win last time goes first
      2'b11:   grant = (last_grant == REQ_MEM) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: clears r1..r(2**D-1) after reset, then
// round-robins ALU and MEM writeback requests onto registered write pins.
module rf_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned W = RF_W,
  parameter int unsigned D = RF_D
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         alu_valid,
  input  logic [D-1:0] alu_waddr,
  input  logic [W-1:0] alu_data,
  output logic         alu_ready,
  input  logic         mem_valid,
  input  logic [D-1:0] mem_waddr,
  input  logic [W-1:0] mem_data,
  output logic         mem_ready,
  output logic         rf_write_en,
  output logic [D-1:0] rf_waddr,
  output logic [W-1:0] rf_data_in,
  output logic         init_done,
  output logic         zero_drop
);

  localparam logic [D-1:0] PTR_LAST = '1;

  rf_state_t    state_q, state_d;
  rf_req_t      last_grant_q, last_grant_d;
  logic [D-1:0] ptr_q, ptr_d;
  logic         we_q, we_d;
  logic [D-1:0] waddr_q, waddr_d;
  logic [W-1:0] data_q, data_d;
  logic         init_done_q, init_done_d;
  logic         zero_drop_q, zero_drop_d;

  logic [1:0]   grant;
  logic         hs;
  logic [D-1:0] hs_addr;
  logic [W-1:0] hs_data;

  rr_arb2 u_arb (
    .req        ({mem_valid, alu_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Readies are combinational so the requester sees acceptance in the same cycle
  always_comb begin
    alu_ready = (state_q == S_RUN) & alu_valid & grant[0];
    mem_ready = (state_q == S_RUN) & mem_valid & grant[1];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ptr_d        = ptr_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    data_d       = data_q;
    init_done_d  = init_done_q;
    zero_drop_d  = zero_drop_q;
    hs           = 1'b0;
    hs_addr      = '0;
    hs_data      = '0;

    case (state_q)
      S_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = ptr_q;
        data_d  = '0;
        ptr_d   = ptr_q + D'(1);
        // End by compare, not wrap, so r0 is never swept
        if (ptr_q == PTR_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        init_done_d = 1'b1;
        if (alu_ready) begin
          hs           = 1'b1;
          hs_addr      = alu_waddr;
          hs_data      = alu_data;
          last_grant_d = REQ_ALU;
        end else if (mem_ready) begin
          hs           = 1'b1;
          hs_addr      = mem_waddr;
          hs_data      = mem_data;
          last_grant_d = REQ_MEM;
        end
        // r0 is hard-wired: accept and discard, but remember it happened
        if (hs) begin
          if (hs_addr == '0) begin
            zero_drop_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            waddr_d = hs_addr;
            data_d  = hs_data;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_CLEAR;
      last_grant_q <= REQ_MEM;
      ptr_q        <= D'(1);
      we_q         <= 1'b0;
      waddr_q      <= '0;
      data_q       <= '0;
      init_done_q  <= 1'b0;
      zero_drop_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ptr_q        <= ptr_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      data_q       <= data_d;
      init_done_q  <= init_done_d;
      zero_drop_q  <= zero_drop_d;
    end
  end

  assign rf_write_en = we_q;
  assign rf_waddr    = waddr_q;
  assign rf_data_in  = data_q;
  assign init_done   = init_done_q;
  assign zero_drop   = zero_drop_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (W=8, D=4) with immediate-assertion checks.
module tb_rf_write_arbiter;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         alu_valid, mem_valid;
  logic [D-1:0] alu_waddr, mem_waddr;
  logic [W-1:0] alu_data, mem_data;
  logic         alu_ready, mem_ready;
  logic         rf_write_en, init_done, zero_drop;
  logic [D-1:0] rf_waddr;
  logic [W-1:0] rf_data_in;

  int checks   = 0;
  int failures = 0;

  rf_write_arbiter #(.W(W), .D(D)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .alu_valid   (alu_valid),
    .alu_waddr   (alu_waddr),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_waddr   (mem_waddr),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .rf_write_en (rf_write_en),
    .rf_waddr    (rf_waddr),
    .rf_data_in  (rf_data_in),
    .init_done   (init_done),
    .zero_drop   (zero_drop)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [D-1:0] a,
                        input logic [W-1:0] d);
    chk({tag, ".we"},   32'(rf_write_en), 32'(we));
    chk({tag, ".addr"}, 32'(rf_waddr),    32'(a));
    chk({tag, ".data"}, 32'(rf_data_in),  32'(d));
  endtask

  task automatic sweep(input string tag);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk_wr($sformatf("%s.c%0d", tag, i), 1'b1, D'(i), 8'h00);
      chk({tag, ".init_lo"}, 32'(init_done), 32'd0);
      chk({tag, ".rdy"}, 32'({alu_ready, mem_ready}), 32'd0);
    end
    step();
    chk({tag, ".init_hi"}, 32'(init_done), 32'd1);
    chk({tag, ".we_idle"}, 32'(rf_write_en), 32'd0);
  endtask

  initial begin
    Reset     = 1'b1;
    alu_valid = 1'b0; alu_waddr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_waddr = '0; mem_data = '0;
    step();
    step();

    // Reset state
    chk_wr("rst", 1'b0, 4'd0, 8'h00);
    chk("rst.init",  32'(init_done), 32'd0);
    chk("rst.zdrop", 32'(zero_drop), 32'd0);

    // 1. Clear sweep r1..r15
    Reset = 1'b0;
    sweep("sweep");

    // 3. Both valid to r5: ALU wins first tie, MEM follows, MEM data persists
    alu_valid = 1'b1; alu_waddr = 4'd5; alu_data = 8'h11;
    mem_valid = 1'b1; mem_waddr = 4'd5; mem_data = 8'h22;
    #1;
    chk("tie.alu_rdy", 32'(alu_ready), 32'd1);
    chk("tie.mem_rdy", 32'(mem_ready), 32'd0);
    step();
    alu_valid = 1'b0;
    #1;
    chk_wr("tie.w1", 1'b1, 4'd5, 8'h11);
    chk("tie.mem_rdy2", 32'(mem_ready), 32'd1);
    step();
    mem_valid = 1'b0;
    #1;
    chk_wr("tie.w2", 1'b1, 4'd5, 8'h22);

    // 4. MEM held while ALU issues back-to-back: ALU / MEM / ALU
    alu_valid = 1'b1; alu_waddr = 4'd6; alu_data = 8'h31;
    mem_valid = 1'b1; mem_waddr = 4'd7; mem_data = 8'h41;
    #1;
    chk("alt.g1", 32'({mem_ready, alu_ready}), 32'b01);
    step();
    alu_waddr = 4'd8; alu_data = 8'h32;
    #1;
    chk_wr("alt.w1", 1'b1, 4'd6, 8'h31);
    chk("alt.g2", 32'({mem_ready, alu_ready}), 32'b10);
    step();
    mem_valid = 1'b0;
    #1;
    chk_wr("alt.w2", 1'b1, 4'd7, 8'h41);
    chk("alt.g3", 32'({mem_ready, alu_ready}), 32'b01);
    step();
    alu_valid = 1'b0;
    #1;
    chk_wr("alt.w3", 1'b1, 4'd8, 8'h32);

    // 2. Single ALU write to r3
    alu_valid = 1'b1; alu_waddr = 4'd3; alu_data = 8'hA5;
    #1;
    chk("alu.rdy", 32'(alu_ready), 32'd1);
    step();
    alu_valid = 1'b0;
    #1;
    chk_wr("alu.w", 1'b1, 4'd3, 8'hA5);
    step();
    chk_wr("alu.hold", 1'b0, 4'd3, 8'hA5);

    // MEM-only request wins without contention
    mem_valid = 1'b1; mem_waddr = 4'd9; mem_data = 8'h5C;
    #1;
    chk("mem.rdy", 32'({mem_ready, alu_ready}), 32'b10);
    step();
    mem_valid = 1'b0;
    #1;
    chk_wr("mem.w", 1'b1, 4'd9, 8'h5C);

    // 5. Write to r0 is accepted and dropped, zero_drop is sticky
    alu_valid = 1'b1; alu_waddr = 4'd0; alu_data = 8'hFF;
    #1;
    chk("r0.rdy", 32'(alu_ready), 32'd1);
    chk("r0.zd_pre", 32'(zero_drop), 32'd0);
    step();
    alu_valid = 1'b0;
    #1;
    chk_wr("r0.w", 1'b0, 4'd9, 8'h5C);
    chk("r0.zd", 32'(zero_drop), 32'd1);
    step();
    step();
    chk("r0.zd_sticky", 32'(zero_drop), 32'd1);

    // 6. Reset while the sweep is at r7
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    chk("mid.at7", 32'(rf_waddr), 32'd7);
    Reset = 1'b1;
    #1;
    chk_wr("mid.rst", 1'b0, 4'd0, 8'h00);
    chk("mid.init", 32'(init_done), 32'd0);
    chk("mid.zd",   32'(zero_drop), 32'd0);
    step();
    Reset = 1'b0;
    sweep("resweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
